regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the MiniMIPS32 pipeline.
- Successor to the single-write, two-read register file; sits between the ID stage (reads), the WB stage (writes) and the issue logic (scoreboard).
- Adds:
  - configurable data width, register count and read-port count;
  - two write ports with defined priority;
  - write-through bypass on every read port;
  - a per-register pending-write scoreboard with busy count, so ID can stall on RAW hazards without external tracking.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 2; register 0 is hard-wired zero.
- AW, log2(NREG), register address width (derived).
- NRD, 2, number of read ports, 1..4.

Ports:
- cpu_clk_75M  in  1  core clock; all state updates on its rising edge.
- cpu_rst_n  in  1  synchronous active-low reset, sampled on the rising edge of cpu_clk_75M.
- we0  in  1  write port 0 enable.
- waddr0  in  AW  write port 0 address.
- wdata0  in  DW  write port 0 data.
- we1  in  1  write port 1 enable; higher priority than port 0.
- waddr1  in  AW  write port 1 address.
- wdata1  in  DW  write port 1 data.
- rd_en  in  NRD  per-read-port enable.
- rd_addr  in  NRD*AW  read addresses, flattened; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*DW  read data, flattened; combinational.
- rd_busy  out  NRD  per-port hazard flag: the addressed register has a write pending that is not being completed this cycle.
- iss_valid  in  1  issue of an instruction that will write iss_addr.
- iss_addr  in  AW  destination register of the issuing instruction.
- busy_cnt  out  AW+1  number of registers currently marked busy (registered).
- debug_addr  in  AW  debug read address.
- debug_data  out  DW  raw array contents at debug_addr; no bypass.

Behaviour:
- Reset: on a rising edge with cpu_rst_n=0, all NREG registers are cleared, all busy bits are cleared and busy_cnt becomes 0. While cpu_rst_n=0, rd_data=0 and rd_busy=0 (combinational gating). Writes and issues presented during a reset cycle are discarded.
- Write: at the clock edge, port k (k=0,1) with wek=1 and waddrk!=0 stores wdatak.
  - If both ports target the same non-zero address, port 1's data is stored.
  - A write to register 0 is ignored.
- Read port i, combinational, evaluated in priority order:
  - cpu_rst_n=0 -> 0;
  - rd_en[i]=0 -> 0;
  - addr=0 -> 0;
  - we1 with waddr1==addr -> wdata1;
  - we0 with waddr0==addr -> wdata0;
  - otherwise the array value.
  - Read latency is zero cycles, with same-cycle write-through.
- Scoreboard, one busy bit per register:
  - The bit is set at the edge when iss_valid=1 and iss_addr!=0.
  - The bit is cleared at the edge when any write port writes that address.
  - If an issue and a write to the same address occur in the same cycle, set wins, because the issuing instruction is the newer writer.
  - Register 0 is never busy.
  - Issuing to an already-busy register leaves it busy; there is no nesting count.
- rd_busy[i] = rd_en[i] and addr!=0 and busy[addr] and no write port writing addr this cycle. In that case rd_data still shows the bypassed value and rd_busy=0.
- busy_cnt: registered population count of the busy bits, updated on the same edge as the bits.
  - Per-cycle change ranges from -2 to +1.
  - Maximum value is NREG-1.
- debug_data = array[debug_addr], asynchronous read.
- Reset mid-operation: pending busy bits are lost. Upstream is flushed by the same reset.

Decomposition:
- Shared package / defines: RstEnable (1'b0), WriteEnable (1'b1), ReadEnable (1'b1), ZeroWord, default DW/NREG constants, and a clog2 helper function.
- One sub-module: regfile_scoreboard. It takes the issue and write-clear inputs and outputs the busy vector and busy_cnt.
- The data array, write logic and per-port bypass muxes are generated inline in regfile_mp, with a generate loop over NRD.

Test Plan:
- Reset clear: preload r5=0x1234_5678, hold cpu_rst_n=0 for 1 edge, release, then read r5 -> rd_data=0, busy_cnt=0.
- Write/read with bypass: write r7=0xDEAD_BEEF on we0 and read r7 in the same cycle -> 0xDEAD_BEEF. On the next cycle, with the write deasserted -> still 0xDEAD_BEEF from the array.
- Dual-write priority: we0 r9=0x1111_1111 and we1 r9=0x2222_2222 in the same cycle. Read in the same cycle -> 0x2222_2222; read after the edge -> 0x2222_2222.
- Register 0: write r0=0xFFFF_FFFF and issue r0 -> reads return 0, rd_busy=0, busy_cnt unchanged.
- Scoreboard: issue r3 -> busy_cnt=1 and a read of r3 gives rd_busy=1. Write r3=0x55 -> rd_busy=0 and rd_data=0x55 in the same cycle; busy_cnt=0 after the edge.
- Set-wins: r4 busy, then in one cycle write r4 and issue r4 -> r4 stays busy, busy_cnt stays 1. Run NRD=4 with a random mix checked against a reference model.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants, default sizes and a clog2 helper for the multi-port register file
package regfile_mp_pkg;
  localparam logic RstEnable = 1'b0;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable = 1'b1;
  localparam int DefDW = 32;
  localparam int DefNREG = 32;
  localparam logic [DefDW-1:0] ZeroWord = '0;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundled write, read, issue and debug signals of the register file
// master drives writes/reads/issue/debug address; slave returns read data, hazards, busy count, debug data
interface regfile_mp_if import regfile_mp_pkg::*; #(
  parameter int DW = DefDW,
  parameter int AW = 5,
  parameter int NRD = 2
);
  logic we0;
  logic [AW-1:0] waddr0;
  logic [DW-1:0] wdata0;
  logic we1;
  logic [AW-1:0] waddr1;
  logic [DW-1:0] wdata1;
  logic [NRD-1:0] rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic iss_valid;
  logic [AW-1:0] iss_addr;
  logic [AW:0] busy_cnt;
  logic [AW-1:0] debug_addr;
  logic [DW-1:0] debug_data;
  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, rd_en, rd_addr, iss_valid, iss_addr, debug_addr,
    input rd_data, rd_busy, busy_cnt, debug_data
  );
  modport slave (
    input we0, waddr0, wdata0, we1, waddr1, wdata1, rd_en, rd_addr, iss_valid, iss_addr, debug_addr,
    output rd_data, rd_busy, busy_cnt, debug_data
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits and their registered population count
// ports: clock/reset, issue (iss_valid_i/iss_addr_i), per-register write clear mask clr_i, busy_o, busy_cnt_o
module regfile_scoreboard import regfile_mp_pkg::*; #(
  parameter int NREG = DefNREG,
  parameter int AW = clog2(NREG)
) (
  input  logic            cpu_clk_75M,
  input  logic            cpu_rst_n,
  input  logic            iss_valid_i,
  input  logic [AW-1:0]   iss_addr_i,
  input  logic [NREG-1:0] clr_i,
  output logic [NREG-1:0] busy_o,
  output logic [AW:0]     busy_cnt_o
);
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (iss_valid_i) busy_d[iss_addr_i] = 1'b1; // set after clear: the issuing instruction is the newer writer
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < NREG; r++) cnt_d = cnt_d + (AW+1)'(busy_d[r]);
  end
  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst_n == RstEnable) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy_o = busy_q;
  assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-write, NRD-read register file with write-through bypass and RAW scoreboard
// ports: cpu_clk_75M, cpu_rst_n (sync active-low), bus (regfile_mp_if.slave: writes, reads, issue, debug)
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int DW = DefDW,
  parameter int NREG = DefNREG,
  parameter int NRD = 2
) (
  input logic cpu_clk_75M,
  input logic cpu_rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = clog2(NREG);
  logic [DW-1:0] mem_q [NREG];
  logic wr0, wr1;
  logic [NREG-1:0] clr, busy;
  logic [AW:0] busy_cnt;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  assign wr0 = bus.we0 == WriteEnable && bus.waddr0 != '0;
  assign wr1 = bus.we1 == WriteEnable && bus.waddr1 != '0;
  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst_n == RstEnable) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= ZeroWord;
    end else begin
      if (wr0) mem_q[bus.waddr0] <= bus.wdata0;
      if (wr1) mem_q[bus.waddr1] <= bus.wdata1; // later assignment gives port 1 priority
    end
  end
  always_comb begin
    clr = '0;
    for (int r = 0; r < NREG; r++) clr[r] = (wr0 && bus.waddr0 == AW'(r)) || (wr1 && bus.waddr1 == AW'(r));
  end
  regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .cpu_clk_75M(cpu_clk_75M),
    .cpu_rst_n(cpu_rst_n),
    .iss_valid_i(bus.iss_valid),
    .iss_addr_i(bus.iss_addr),
    .clr_i(clr),
    .busy_o(busy),
    .busy_cnt_o(busy_cnt)
  );
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic h0, h1, on;
    assign a = bus.rd_addr[i*AW +: AW];
    assign h0 = bus.we0 == WriteEnable && bus.waddr0 == a;
    assign h1 = bus.we1 == WriteEnable && bus.waddr1 == a;
    assign on = cpu_rst_n != RstEnable && bus.rd_en[i] == ReadEnable && a != '0;
    assign rd_data[i*DW +: DW] = !on ? ZeroWord : h1 ? bus.wdata1 : h0 ? bus.wdata0 : mem_q[a];
    assign rd_busy[i] = on && busy[a] && !h0 && !h1; // a write landing now resolves the hazard via bypass
  end
  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;
  assign bus.busy_cnt = busy_cnt;
  assign bus.debug_data = mem_q[bus.debug_addr];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed scoreboard bench for regfile_mp with NRD=4
module tb_regfile_mp;
  localparam int DW = 32, NREG = 32, AW = 5, NRD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  regfile_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();
  regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD)) dut (
    .cpu_clk_75M(clk),
    .cpu_rst_n(rst_n),
    .bus(bus.slave)
  );
  typedef struct {
    string tag;
    bit known;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0] bz;
    logic [AW:0] cnt;
    logic [DW-1:0] dbg;
  } exp_t;
  exp_t q[$];
  exp_t m;
  logic [DW-1:0] mem [NREG];
  bit busy [NREG];
  bit known = 0;
  int checks = 0, failures = 0;
  function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a, logic en);
    if (!rst_n || !en || a == 0) return '0;
    if (bus.we1 && bus.waddr1 == a) return bus.wdata1;
    if (bus.we0 && bus.waddr0 == a) return bus.wdata0;
    return mem[a];
  endfunction
  function automatic logic ref_busy(logic [AW-1:0] a, logic en);
    if (!rst_n || !en || a == 0) return 1'b0;
    if ((bus.we1 && bus.waddr1 == a) || (bus.we0 && bus.waddr0 == a)) return 1'b0;
    return busy[a];
  endfunction
  function automatic logic [AW-1:0] rnd_addr();
    return $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG-1));
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rst_n = 1'b1;
    bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.rd_en = '0; bus.rd_addr = '0;
    bus.iss_valid = 0; bus.iss_addr = '0;
    bus.debug_addr = '0;
  endtask
  task automatic drive(string tag);
    exp_t e;
    int n = 0;
    e.tag = tag;
    e.known = known;
    for (int i = 0; i < NRD; i++) begin
      e.rd[i*DW +: DW] = ref_read(bus.rd_addr[i*AW +: AW], bus.rd_en[i]);
      e.bz[i] = ref_busy(bus.rd_addr[i*AW +: AW], bus.rd_en[i]);
    end
    for (int r = 0; r < NREG; r++) n += int'(busy[r]);
    e.cnt = (AW+1)'(n);
    e.dbg = mem[bus.debug_addr];
    q.push_back(e);
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] = '0;
        busy[r] = 0;
      end
      known = 1;
    end else begin
      if (bus.we0 && bus.waddr0 != 0) begin mem[bus.waddr0] = bus.wdata0; busy[bus.waddr0] = 0; end
      if (bus.we1 && bus.waddr1 != 0) begin mem[bus.waddr1] = bus.wdata1; busy[bus.waddr1] = 0; end
      if (bus.iss_valid && bus.iss_addr != 0) busy[bus.iss_addr] = 1;
    end
  endtask
  task automatic chk(string tag, string what, logic [NRD*DW-1:0] got, logic [NRD*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s %s got=%h exp=%h at %0t", tag, what, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      chk(m.tag, "rd_data", bus.rd_data, m.rd);
      chk(m.tag, "rd_busy", (NRD*DW)'(bus.rd_busy), (NRD*DW)'(m.bz));
      if (m.known) begin
        chk(m.tag, "busy_cnt", (NRD*DW)'(bus.busy_cnt), (NRD*DW)'(m.cnt));
        chk(m.tag, "debug_data", (NRD*DW)'(bus.debug_data), (NRD*DW)'(m.dbg));
      end
    end
  end
  initial begin
    idle();
    rst_n = 1'b0;
    tick(); idle(); rst_n = 0; bus.rd_en = '1; drive("reset0");
    tick(); idle(); rst_n = 0; bus.rd_en = '1; drive("reset1");
    tick(); idle(); bus.we0 = 1; bus.waddr0 = 5; bus.wdata0 = 32'h1234_5678; bus.rd_en = 4'b0001; bus.rd_addr = {4{5'd5}}; drive("preload_r5");
    tick(); idle(); rst_n = 0; bus.rd_en = '1; bus.rd_addr = {4{5'd5}}; bus.debug_addr = 5; drive("rst_hold");
    tick(); idle(); bus.rd_en = '1; bus.rd_addr = {4{5'd5}}; bus.debug_addr = 5; drive("rst_clear");
    tick(); idle(); bus.we0 = 1; bus.waddr0 = 7; bus.wdata0 = 32'hDEAD_BEEF; bus.rd_en = 4'b0001; bus.rd_addr = {15'd0, 5'd7}; drive("bypass_r7");
    tick(); idle(); bus.rd_en = 4'b0100; bus.rd_addr = {5'd0, 5'd7, 10'd0}; bus.debug_addr = 7; drive("array_r7");
    tick(); idle(); bus.we0 = 1; bus.waddr0 = 9; bus.wdata0 = 32'h1111_1111; bus.we1 = 1; bus.waddr1 = 9; bus.wdata1 = 32'h2222_2222;
    bus.rd_en = 4'b0011; bus.rd_addr = {10'd0, 5'd9, 5'd9}; drive("dual_same");
    tick(); idle(); bus.rd_en = 4'b1000; bus.rd_addr = {5'd9, 15'd0}; bus.debug_addr = 9; drive("dual_after");
    tick(); idle(); bus.iss_valid = 1; bus.iss_addr = 3; bus.rd_en = 4'b0001; bus.rd_addr = {15'd0, 5'd3}; drive("iss_r3");
    tick(); idle(); bus.rd_en = 4'b0011; bus.rd_addr = {10'd0, 5'd3, 5'd3}; drive("busy_r3");
    tick(); idle(); bus.we1 = 1; bus.waddr1 = 3; bus.wdata1 = 32'h55; bus.rd_en = 4'b0001; bus.rd_addr = {15'd0, 5'd3}; drive("clr_r3");
    tick(); idle(); bus.rd_en = 4'b0001; bus.rd_addr = {15'd0, 5'd3}; drive("after_clr_r3");
    tick(); idle(); bus.iss_valid = 1; bus.iss_addr = 4; drive("iss_r4");
    tick(); idle(); bus.we0 = 1; bus.waddr0 = 4; bus.wdata0 = 32'hAA; bus.iss_valid = 1; bus.iss_addr = 4;
    bus.rd_en = 4'b0001; bus.rd_addr = {15'd0, 5'd4}; drive("set_wins");
    tick(); idle(); bus.rd_en = 4'b0001; bus.rd_addr = {15'd0, 5'd4}; drive("still_busy_r4");
    tick(); idle(); bus.we0 = 1; bus.wdata0 = '1; bus.we1 = 1; bus.wdata1 = '1; bus.iss_valid = 1; bus.rd_en = '1; drive("r0_write_issue");
    tick(); idle(); bus.rd_en = '1; drive("r0_after");
    repeat (3000) begin
      tick(); idle();
      rst_n = $urandom_range(0, 99) != 0;
      bus.we0 = $urandom_range(0, 2) == 0; bus.waddr0 = rnd_addr(); bus.wdata0 = $urandom;
      bus.we1 = $urandom_range(0, 2) == 0; bus.waddr1 = rnd_addr(); bus.wdata1 = $urandom;
      bus.iss_valid = $urandom_range(0, 1) == 0; bus.iss_addr = rnd_addr();
      bus.rd_en = NRD'($urandom_range(0, 15));
      for (int i = 0; i < NRD; i++) bus.rd_addr[i*AW +: AW] = rnd_addr();
      bus.debug_addr = rnd_addr();
      drive("rand");
    end
    tick(); idle();
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
